// File: rtl/mac.sv
// Unsigned 16x16 multiply-accumulate into a 36-bit wrapping accumulator.
// The accumulator register drives the output directly, with single-cycle latency.
module mac (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [35:0] out,
    input  logic        clk,
    input  logic        reset
);

    logic [31:0] product_s;
    logic [35:0] acc_d;
    logic [35:0] acc_q;

    // Full-width product and next accumulator value; 4 guard bits, wraps mod 2^36
    always_comb begin
        product_s = {16'd0, A} * {16'd0, B};
        acc_d     = acc_q + {4'd0, product_s};
    end

    // Accumulator register; reset wins over accumulation on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= 36'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out = acc_q;

endmodule

// File: tb/tb_mac.sv
// Scoreboard bench for mac: stimulus pushes expected accumulator values,
// a monitor pops and compares one value after every rising edge.
module tb_mac;

    logic [15:0] a_s;
    logic [15:0] b_s;
    logic [35:0] out_s;
    logic        clk;
    logic        reset_s;

    typedef struct {
        logic [35:0] exp;
        int          tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        checks;
    int        errors;
    longint    model_sum;

    localparam longint MOD36 = 64'd1 << 36;
    localparam longint MAXP  = 64'd65535 * 64'd65535;

    mac dut (
        .A     (a_s),
        .B     (b_s),
        .out   (out_s),
        .clk   (clk),
        .reset (reset_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge worth of inputs and push its expected result.
    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic rst, input longint exp, input int tag);
        sb_entry_t e;
        @(negedge clk);
        a_s     = a;
        b_s     = b;
        reset_s = rst;
        e.exp   = exp[35:0];
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    // Reference model: running sum of products modulo 2^36, cleared by reset.
    task automatic drive_model(input logic [15:0] a, input logic [15:0] b,
                               input logic rst, input int tag);
        if (rst) model_sum = 0;
        else     model_sum = (model_sum + longint'(a) * longint'(b)) % MOD36;
        drive(a, b, rst, model_sum, tag);
    endtask

    // Monitor: after each rising edge compare out against the oldest expectation.
    always @(posedge clk) begin
        sb_entry_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks = checks + 1;
            if (out_s !== e.exp) begin
                errors = errors + 1;
                $display("FAIL check tag=%0d out=%0d expected=%0d", e.tag, out_s, e.exp);
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        checks    = 0;
        errors    = 0;
        model_sum = 0;
        a_s       = 16'd0;
        b_s       = 16'd0;
        reset_s   = 1'b1;

        // Reset held 3 edges with maximal operands
        for (int i = 0; i < 3; i++) drive(16'd65535, 16'd65535, 1'b1, 0, 100 + i);
        drive(16'd3, 16'd4, 1'b0, 12, 200);
        drive(16'd5, 16'd6, 1'b0, 42, 201);
        // Zero operand holds
        drive(16'd0, 16'd9, 1'b0, 42, 300);
        drive(16'd0, 16'd9, 1'b0, 42, 301);
        drive(16'd7, 16'd0, 1'b0, 42, 302);
        // Reset mid-accumulation, then resume from zero
        drive(16'd100, 16'd100, 1'b1, 0, 400);
        drive(16'd2, 16'd2, 1'b0, 4, 401);

        // Sixteen maximal products fit; the seventeenth wraps
        drive(16'd65535, 16'd65535, 1'b1, 0, 500);
        for (int i = 1; i <= 15; i++) drive(16'd65535, 16'd65535, 1'b0, MAXP * i, 500 + i);
        drive(16'd65535, 16'd65535, 1'b0, 64'd68717379600, 516);
        drive(16'd65535, 16'd65535, 1'b0, 64'd4292739089, 517);

        // Randomized run against the model
        drive_model(16'd65535, 16'd65535, 1'b1, 600);
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom_range(65534, 0));
            rb = 16'($urandom_range(65534, 0));
            drive_model(ra, rb, 1'b0, 1000 + i);
        end

        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        #3;
        if (sb_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac.md
MAC -- requirements
Module: mac

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 SHALL declare ports in the order A, B, out, clk, reset, so positional instantiation works.
REQ-004 clk  input  1  rising-edge clock; all state updates occur on this edge only.
REQ-005 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-006 A  input  16  unsigned multiplicand, sampled on the rising edge of clk.
REQ-007 B  input  16  unsigned multiplier, sampled on the rising edge of clk.
REQ-008 out  output  36  unsigned accumulator value, driven directly from a register.

Function
REQ-009 SHALL compute the full unsigned 32-bit product P = A*B from the A and B values present at each rising edge.
REQ-010 SHALL update out <= out + P (zero-extended to 36 bits) on every rising edge where reset = 0.
REQ-011 SHALL have single-cycle latency: the product of the operands sampled at edge k appears in out immediately after edge k.
REQ-012 SHALL treat the accumulator as 36 bits (32-bit product plus 4 guard bits), so at least 16 maximum products accumulate without overflow.
REQ-013 SHALL wrap modulo 2^36 on overflow, with no saturation and no overflow flag.
REQ-014 SHALL accumulate unconditionally; the block has no enable or valid input.
REQ-015 SHALL treat A=0 or B=0 as a hold, leaving out unchanged.
REQ-016 SHALL keep out free of combinational paths from A, B or reset.
REQ-017 SHALL produce no X on out after the first reset edge, for any known A and B.

Reset
REQ-018 SHALL load out <= 0 on a rising edge where reset = 1, discarding that cycle's product.
REQ-019 SHALL give reset priority over accumulation when both occur on the same edge.
REQ-020 SHALL accept reset mid-accumulation: out becomes 0 at the next edge, and accumulation resumes from 0 on the first edge with reset = 0.
REQ-021 SHALL leave out undefined before the first reset edge; the bench SHALL assert reset for at least one clk edge at start.

Verification
REQ-022 Hold reset=1 for 3 edges with A=65535 and B=65535 -> out=0 after each edge.
REQ-023 Release reset, then apply A=3,B=4 for one edge, then A=5,B=6 for one edge -> out=12, then out=42.
REQ-024 With out=42, apply A=0,B=9 for 2 edges and then A=7,B=0 for 1 edge -> out stays 42 throughout.
REQ-025 From out=0, apply A=B=65535 for 16 edges -> out=68717379600; apply a 17th edge -> out=4292739089 (wrap modulo 2^36).
REQ-026 With out=42, assert reset for 1 edge while A=100,B=100, then deassert with A=2,B=2 -> out=0, then out=4.
REQ-027 Apply random A,B (uniform over 0..65534) for 100 edges after reset -> out matches a reference model of (sum of A*B) mod 2^36 after every edge.
